motion_cmd_fifo: RTL
====================

// Module: motion_cmd_fifo
// PURPOSE
// Parametrised command queue between the HPS command PIO registers and the motion core.
// HPS writes type, per-axis targets and feedrate, then toggles one flag bit; each toggle enqueues one command.
// The motion core drains commands with a valid/ready handshake.
// Fill level, full/empty, sticky overflow, an acknowledge toggle and a pop counter return to HPS via the flags PIO.
// PARAMETERS
// AXES   5   number of axis target fields (X,Y,Z,E0,E1)
// DW     32  width of each axis target and of the feedrate field
// TW     8   width of the command type field
// DEPTH  16  queue entries; power of two, >= 2
// AW     $clog2(DEPTH)  pointer width (derived, not overridable)
// PORTS
// clk_clk      in   1        system clock, all logic rising-edge
// reset_reset  in   1        asynchronous, active-high reset
// cmd_type_in  in   TW       command type from HPS PIO
// cmd_axes_in  in   AXES*DW  packed targets; axis i at [i*DW +: DW]
// cmd_f_in     in   DW       feedrate
// cmd_tgl_in   in   1        push request: any change of level = one push
// flush_in     in   1        synchronous queue clear (level-sensitive)
// ovf_clr_in   in   1        clears sticky overflow
// m_valid      out  1        head entry available
// m_ready      in   1        motion core accepts head entry
// m_type       out  TW       head type
// m_axes       out  AXES*DW  head targets
// m_f          out  DW       head feedrate
// ack_tgl      out  1        copies cmd_tgl_in when the push is consumed
// level        out  AW+1     entries held, 0..DEPTH
// full         out  1        level == DEPTH
// empty        out  1        level == 0
// overflow     out  1        sticky: a push was dropped
// pop_count    out  16       accepted pops, wraps 0xFFFF->0
// BEHAVIOUR
// - Reset (async, any time): wr/rd pointers, level, tgl_q, ack_tgl, overflow and pop_count go to 0.
//   m_valid=0, empty=1, full=0. Storage array is not reset. Reset mid-transfer discards all entries.
// - Edge detect: tgl_q <= cmd_tgl_in each cycle. push = (cmd_tgl_in != tgl_q); one push per change.
// - Pop: pop = m_valid & m_ready.
// - Push acceptance: accepted when !full, or when full and pop is in the same cycle.
//   Accepted push writes {type, axes, f} at wr_ptr, advances wr_ptr, ack_tgl <= cmd_tgl_in.
// - Dropped push (full, no pop): overflow <= 1; ack_tgl unchanged; no entry is written.
// - Level: +1 on push only, -1 on pop only, unchanged on simultaneous push+pop.
//   Pointers are AW bits and wrap modulo DEPTH.
// - Output (first-word fall-through): m_valid = !empty.
//   m_* = mem[rd_ptr] when valid, else 0. m_* is stable while m_valid & !m_ready.
//   A push into an empty queue raises m_valid on the cycle after the push edge.
// - pop_count: +1 on each pop, 16-bit wrap.
// - Flush has priority over push and pop. It clears pointers and level; m_valid=0 on the next cycle.
//   A push seen in the flush cycle is discarded, but ack_tgl still follows it so HPS does not stall.
//   Flush does not change overflow or pop_count.
// - ovf_clr_in clears overflow. If a drop occurs in the same cycle, set wins.
// - m_ready while empty has no effect.
// TESTING
// - Reset, toggle cmd_tgl_in once with type=0x01, X=100, F=3000.
//   -> m_valid=1 one cycle later, m_type=0x01, m_axes[31:0]=100, level=1, ack_tgl=1.
// - Hold m_ready=0, push 16 commands.
//   -> full=1, level=16. 17th toggle -> overflow=1, ack_tgl unchanged, level=16.
//   ovf_clr_in -> overflow=0.
// - Full queue with m_ready=1 and a push in the same cycle.
//   -> push accepted, level stays 16, no overflow, FIFO order preserved on drain.
// - Push 3, assert flush_in together with a push.
//   -> level=0, m_valid=0 next cycle, ack_tgl follows, pop_count unchanged.
// - Stream 70000 push/pop pairs with random m_ready.
//   -> pop_count = 70000 mod 65536 = 4464, data order matches scoreboard, pointers wrap cleanly.
// - Assert reset_reset asynchronously mid-stream with 5 entries held.
//   -> all outputs at reset values immediately. First push after release lands at entry 0.

Source files
------------

// File: rtl/motion_cmd_fifo.sv
// Command queue between the HPS command PIO and the motion core: toggle-driven push,
// first-word fall-through pop, status (level/full/empty/overflow/ack/pop count) back to HPS.
module motion_cmd_fifo #(
    parameter int AXES  = 5,
    parameter int DW    = 32,
    parameter int TW    = 8,
    parameter int DEPTH = 16
) (
    input  logic                 clk_clk,
    input  logic                 reset_reset,
    input  logic [TW-1:0]        cmd_type_in,
    input  logic [AXES*DW-1:0]   cmd_axes_in,
    input  logic [DW-1:0]        cmd_f_in,
    input  logic                 cmd_tgl_in,
    input  logic                 flush_in,
    input  logic                 ovf_clr_in,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [TW-1:0]        m_type,
    output logic [AXES*DW-1:0]   m_axes,
    output logic [DW-1:0]        m_f,
    output logic                 ack_tgl,
    output logic [$clog2(DEPTH):0] level,
    output logic                 full,
    output logic                 empty,
    output logic                 overflow,
    output logic [15:0]          pop_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = TW + AXES * DW + DW;
    localparam logic [AW:0] LVL_FULL = (AW + 1)'(DEPTH);

    logic [EW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          tgl_q;
    logic          ack_q, ack_d;
    logic          ovf_q, ovf_d;
    logic [15:0]   pop_cnt_q, pop_cnt_d;

    logic          push, pop, push_ok, drop;
    logic          full_w, empty_w;
    logic [EW-1:0] head;

    // Handshake: m_valid is high whenever the queue holds an entry; a transfer happens on
    // every rising edge where m_valid && m_ready. m_* hold steady until that transfer.
    always_comb begin
        full_w  = (level_q == LVL_FULL);
        empty_w = (level_q == '0);
        push    = cmd_tgl_in ^ tgl_q;
        pop     = !empty_w && m_ready;
        // A full queue still takes a push when the head leaves in the same cycle.
        push_ok = push && (!full_w || pop) && !flush_in;
        drop    = push && full_w && !pop && !flush_in;
    end

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        ack_d     = ack_q;
        pop_cnt_d = pop_cnt_q;
        if (flush_in) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            // Acknowledge the discarded push anyway so the HPS handshake never stalls.
            if (push) begin
                ack_d = cmd_tgl_in;
            end
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
                ack_d    = cmd_tgl_in;
            end
            if (pop) begin
                rd_ptr_d  = rd_ptr_q + AW'(1);
                pop_cnt_d = pop_cnt_q + 16'd1;
            end
            if (push_ok && !pop) begin
                level_d = level_q + (AW + 1)'(1);
            end else if (pop && !push_ok) begin
                level_d = level_q - (AW + 1)'(1);
            end
        end
        if (drop) begin
            ovf_d = 1'b1;
        end else if (ovf_clr_in) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            tgl_q     <= 1'b0;
            ack_q     <= 1'b0;
            ovf_q     <= 1'b0;
            pop_cnt_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            tgl_q     <= cmd_tgl_in;
            ack_q     <= ack_d;
            ovf_q     <= ovf_d;
            pop_cnt_q <= pop_cnt_d;
        end
    end

    // Storage carries no reset; stale words are never visible because m_* are masked when empty.
    always_ff @(posedge clk_clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= {cmd_type_in, cmd_axes_in, cmd_f_in};
        end
    end

    always_comb begin
        head = empty_w ? '0 : mem_q[rd_ptr_q];
    end

    assign m_valid   = !empty_w;
    assign m_type    = head[EW-1 -: TW];
    assign m_axes    = head[DW +: AXES*DW];
    assign m_f       = head[DW-1:0];
    assign ack_tgl   = ack_q;
    assign level     = level_q;
    assign full      = full_w;
    assign empty     = empty_w;
    assign overflow  = ovf_q;
    assign pop_count = pop_cnt_q;

endmodule
